// File: rtl/scan_pkg.sv
// Shared types and limits for the truth-table scanner.
package scan_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} scan_state_t;

    localparam int N_IN_MAX   = 6;
    localparam int SETTLE_MAX = 15;

    function automatic int tbl_w(input int n);
        return 1 << n;
    endfunction
endpackage

// File: rtl/scan_settle_timer.sv
// Settle counter: counts hold cycles of one drive value, flags the last one.
module scan_settle_timer
    import scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(SETTLE_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == CW'(SETTLE - 1));
endmodule

// File: rtl/truth_table_scanner.sv
// Walks every minterm of an N_IN-input function in order, holds each for SETTLE
// cycles, then samples the function output into the corresponding table bit.
module truth_table_scanner
    import scan_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    s_in,
    output logic [N_IN-1:0]         drive,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic [tbl_w(N_IN)-1:0]  table_out
);
    localparam int TW = tbl_w(N_IN);
    // One spare index bit keeps the last-minterm compare clear of wraparound.
    localparam logic [N_IN:0] LAST = (N_IN + 1)'(TW - 1);

    generate
        if (N_IN < 1 || N_IN > N_IN_MAX || SETTLE < 1 || SETTLE > SETTLE_MAX) begin : g_param_chk
            $error("truth_table_scanner: N_IN or SETTLE out of range");
        end
    endgenerate

    scan_state_t   state_q, state_d;
    logic [N_IN:0] idx_q, idx_d;
    logic [TW-1:0] tbl_q, tbl_d;
    logic          valid_q, valid_d;
    logic          tmr_clr, tmr_en, tmr_expired;

    scan_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tbl_d   = tbl_q;
        valid_d = valid_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    tbl_d   = '0;
                    valid_d = 1'b0;
                    tmr_clr = 1'b1;
                end
            end
            DRIVE: begin
                tmr_en = 1'b1;
                if (tmr_expired)
                    state_d = SAMPLE;
            end
            SAMPLE: begin
                tbl_d[idx_q[N_IN-1:0]] = s_in;
                tmr_clr = 1'b1;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = DRIVE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tbl_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tbl_q   <= tbl_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
    assign drive     = busy ? idx_q[N_IN-1:0] : '0;
    assign done      = (state_q == DONE);
    assign valid     = valid_q;
    assign table_out = tbl_q;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: stimulus queues expected tables and done cycles, a monitor
// checks them whenever a scanner raises done.
module tb_truth_table_scanner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       mode_a = 1'b0;
    logic [1:0] drive_a;
    logic [2:0] drive_b;
    logic       s_in_a, s_in_b;
    logic       busy_a, done_a, valid_a, busy_b, done_b, valid_b;
    logic [3:0] table_a;
    logic [7:0] table_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct { logic [7:0] tbl; int dcyc; } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode_a: 0 = constant-0 f block, 1 = XOR stub
    assign s_in_a = mode_a ? (drive_a[1] ^ drive_a[0]) : 1'b0;
    assign s_in_b = &drive_b;

    truth_table_scanner #(.N_IN(2), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .s_in(s_in_a), .drive(drive_a),
        .busy(busy_a), .done(done_a), .valid(valid_a), .table_out(table_a));

    truth_table_scanner #(.N_IN(3), .SETTLE(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .s_in(s_in_b), .drive(drive_b),
        .busy(busy_b), .done(done_b), .valid(valid_b), .table_out(table_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done_a === 1'b1) begin
            if (qa.size() == 0) chk("unexpected_done_a", 32'd1, 32'd0);
            else begin
                e = qa.pop_front();
                chk("table_a", 32'(table_a), 32'(e.tbl));
                chk("valid_at_done_a", 32'(valid_a), 32'd1);
                chk("done_cycle_a", cyc, e.dcyc);
            end
        end
        if (done_b === 1'b1) begin
            if (qb.size() == 0) chk("unexpected_done_b", 32'd1, 32'd0);
            else begin
                e = qb.pop_front();
                chk("table_b", 32'(table_b), 32'(e.tbl));
                chk("valid_at_done_b", 32'(valid_b), 32'd1);
                chk("done_cycle_b", cyc, e.dcyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        nxt(); nxt();
        chk("rst_drive_a", 32'(drive_a), 32'd0);
        chk("rst_busy_a",  32'(busy_a),  32'd0);
        chk("rst_done_a",  32'(done_a),  32'd0);
        chk("rst_valid_a", 32'(valid_a), 32'd0);
        chk("rst_table_a", 32'(table_a), 32'd0);
        chk("rst_table_b", 32'(table_b), 32'd0);
        rst = 1'b0;
        nxt();

        // constant-0 function at defaults
        mode_a = 1'b0; start_a = 1'b1; t = cyc;
        qa.push_back('{8'h00, t + 9});
        nxt(); start_a = 1'b0;
        repeat (10) nxt();

        // XOR stub with drive sequence check
        mode_a = 1'b1; start_a = 1'b1; t = cyc;
        qa.push_back('{8'h06, t + 9});
        for (int k = 1; k <= 8; k++) begin
            nxt();
            start_a = 1'b0;
            chk("xor_drive_seq", 32'(drive_a), 32'((k - 1) / 2));
            chk("xor_busy", 32'(busy_a), 32'd1);
        end
        nxt(); // done cycle
        repeat (3) begin
            nxt();
            chk("valid_hold", 32'(valid_a), 32'd1);
            chk("table_hold", 32'(table_a), 32'h6);
        end

        // start re-asserted mid-scan and in DONE is ignored
        start_a = 1'b1; t = cyc;
        qa.push_back('{8'h06, t + 9});
        nxt(); start_a = 1'b0;
        nxt(); nxt();
        start_a = 1'b1; // T+3
        nxt(); start_a = 1'b0;
        while (cyc < t + 9) nxt();
        start_a = 1'b1; // DONE cycle
        nxt(); start_a = 1'b0; // T+10, IDLE
        chk("ignored_start_busy",  32'(busy_a),  32'd0);
        chk("ignored_start_valid", 32'(valid_a), 32'd1);
        start_a = 1'b1; t = cyc;
        qa.push_back('{8'h06, t + 9});
        nxt(); start_a = 1'b0;
        chk("restart_valid_clr", 32'(valid_a), 32'd0);
        chk("restart_busy",      32'(busy_a),  32'd1);
        repeat (10) nxt();

        // reset mid-scan
        start_a = 1'b1; t = cyc;
        nxt(); start_a = 1'b0;
        while (cyc < t + 5) nxt();
        chk("partial_table", 32'(table_a), 32'h2);
        rst = 1'b1;
        nxt(); rst = 1'b0;
        chk("abort_drive", 32'(drive_a), 32'd0);
        chk("abort_busy",  32'(busy_a),  32'd0);
        chk("abort_valid", 32'(valid_a), 32'd0);
        chk("abort_table", 32'(table_a), 32'd0);
        nxt();
        start_a = 1'b1; t = cyc;
        qa.push_back('{8'h06, t + 9});
        nxt(); start_a = 1'b0;
        repeat (10) nxt();

        // rst and start together
        rst = 1'b1; start_a = 1'b1;
        nxt(); rst = 1'b0; start_a = 1'b0;
        chk("rst_start_busy",  32'(busy_a),  32'd0);
        chk("rst_start_valid", 32'(valid_a), 32'd0);
        nxt();
        chk("rst_start_idle", 32'(busy_a), 32'd0);

        // N_IN=3, SETTLE=3 AND3
        start_b = 1'b1; t = cyc;
        qb.push_back('{8'h80, t + 33});
        for (int k = 1; k <= 32; k++) begin
            nxt();
            start_b = 1'b0;
            chk("and3_drive_hold", 32'(drive_b), 32'((k - 1) / 4));
        end
        repeat (3) nxt();

        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
